// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the iterative RV32M divide/remainder unit.
// Holds the data width, the divide op codes, the FSM state encoding and a
// small magnitude helper used when loading signed operands.
package div_unit_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int CNT_W      = 5;

    // Divide/remainder operation select
    localparam logic [1:0] OP_DIV_DIV  = 2'b00;
    localparam logic [1:0] OP_DIV_DIVU = 2'b01;
    localparam logic [1:0] OP_DIV_REM  = 2'b10;
    localparam logic [1:0] OP_DIV_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CALC   = 2'b01,
        ST_FINISH = 2'b10
    } div_state_t;

    // Two's-complement magnitude when neg is set, raw value otherwise.
    // The most negative value maps to itself, which is its correct unsigned magnitude.
    function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] v,
                                                  input logic                  neg);
        return neg ? (~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; 34 cycles from accepted start to o_done.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration
// and finishes one cycle after start.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | waiting for i_start; operands and op latched on accept
//  ST_CALC   | 32 shift/compare/subtract iterations, one per cycle
//  ST_FINISH | sign-correct, register o_c and pulse o_done
module div_unit
    import div_unit_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_c
);

    div_state_t            state_q;
    div_state_t            state_d;

    logic [1:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic                  sign_a_q;
    logic                  sign_b_q;
    logic                  bzero_q;
    logic [DATA_WIDTH-1:0] dvd_q;
    logic [DATA_WIDTH-1:0] dvs_q;
    logic [DATA_WIDTH-1:0] rem_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  start_signed;
    logic [DATA_WIDTH:0]   rem_sh;
    logic [DATA_WIDTH:0]   diff;
    logic                  q_bit;
    logic [DATA_WIDTH-1:0] rem_nx;
    logic [DATA_WIDTH-1:0] dvd_nx;
    logic [DATA_WIDTH-1:0] result;

    // DIV and REM are the signed ops (op bit 0 clear)
    assign start_signed = ~i_op[0];

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and busy flag
    always_comb begin
        state_d = state_q;
        o_busy  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
`ifdef DIV_ZERO_FAST_EN
                    if (i_b == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_CALC;
                    end
`else
                    state_d = ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // One restoring step; the shifted remainder is kept one bit wider so large
    // unsigned divisors compare correctly
    always_comb begin
        rem_sh = {rem_q, dvd_q[DATA_WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        q_bit  = ~diff[DATA_WIDTH];
        rem_nx = q_bit ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
        dvd_nx = {dvd_q[DATA_WIDTH-2:0], q_bit};
    end

    // Sign correction and divide-by-zero result selection
    always_comb begin
        result = '0;
        if (bzero_q) begin
            result = op_q[1] ? a_q : '1;
        end else if (!op_q[1]) begin
            result = mag(dvd_q, sign_a_q ^ sign_b_q);
        end else begin
            result = mag(rem_q, sign_a_q);
        end
    end

    // Operand capture, iteration datapath and registered result
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_q     <= '0;
            a_q      <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            bzero_q  <= 1'b0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            o_c      <= '0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        op_q     <= i_op;
                        a_q      <= i_a;
                        sign_a_q <= start_signed & i_a[DATA_WIDTH-1];
                        sign_b_q <= start_signed & i_b[DATA_WIDTH-1];
                        bzero_q  <= (i_b == '0);
                        dvd_q    <= mag(i_a, start_signed & i_a[DATA_WIDTH-1]);
                        dvs_q    <= mag(i_b, start_signed & i_b[DATA_WIDTH-1]);
                        rem_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_nx;
                    dvd_q <= dvd_nx;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                ST_FINISH: begin
                    o_c    <= result;
                    o_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against a plain
// arithmetic reference of the RV32M divide/remainder rules.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_c;

    int          n_tot;
    int          n_bad;
    logic [31:0] last_c;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT  = 2;
    localparam int ZERO_BUSY = 1;
`else
    localparam int ZERO_LAT  = 34;
    localparam int ZERO_BUSY = 33;
`endif

    div_unit dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_start(i_start),
        .i_op   (i_op),
        .i_a    (i_a),
        .i_b    (i_b),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_c    (o_c)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        if (b == 32'd0) return (op[1] == 1'b0) ? 32'hFFFF_FFFF : a;
        case (op)
            OP_DIV_DIVU: return a / b;
            OP_DIV_REMU: return a % b;
            OP_DIV_DIV: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            default: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
        endcase
    endfunction

    // Called at #1 after an edge; drives a start, lets E0 happen, then scrambles inputs.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        i_start = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        i_op    = 2'($urandom);
        i_a     = $urandom;
        i_b     = $urandom;
        chk("done_width", {31'd0, o_done}, 32'd0);
        chk("c_hold", o_c, last_c);
    endtask

    // Waits for o_done; cyc counts cycles from start (E0 is cycle 1).
    task automatic wait_done(input int c0, output logic [31:0] c, output int cyc,
                             output int busy_n);
        logic got;
        got    = 1'b0;
        cyc    = c0;
        busy_n = o_busy ? 1 : 0;
        for (int k = 0; k < 80 && !got; k++) begin
            @(posedge i_clk);
            #1;
            cyc++;
            if (o_done) got = 1'b1;
            else if (o_busy) busy_n++;
        end
        chk("timeout", {31'd0, got}, 32'd1);
        chk("busy_at_done", {31'd0, o_busy}, 32'd0);
        c      = o_c;
        last_c = o_c;
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        logic [31:0] c;
        int          cyc;
        int          bn;
        start_op(op, a, b);
        wait_done(1, c, cyc, bn);
        chk({tag, "_res"}, c, ref_div(op, a, b));
        chk({tag, "_lat"}, 32'(cyc), (b == 32'd0) ? 32'(ZERO_LAT) : 32'd34);
        chk({tag, "_busy"}, 32'(bn), (b == 32'd0) ? 32'(ZERO_BUSY) : 32'd33);
    endtask

    initial begin
        logic [31:0] c;
        int          cyc;
        int          bn;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        seen_done;

        n_tot   = 0;
        n_bad   = 0;
        last_c  = 32'd0;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_op    = 2'd0;
        i_a     = 32'd0;
        i_b     = 32'd0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_c", o_c, 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // Directed cases
        do_op("divu_100_7", OP_DIV_DIVU, 32'd100, 32'd7);
        chk("divu_100_7_const", last_c, 32'h0000_000E);
        do_op("remu_100_7", OP_DIV_REMU, 32'd100, 32'd7);
        chk("remu_100_7_const", last_c, 32'h0000_0002);
        do_op("div_m7_2", OP_DIV_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2_const", last_c, 32'hFFFF_FFFD);
        do_op("rem_m7_2", OP_DIV_REM, 32'hFFFF_FFF9, 32'd2);
        chk("rem_m7_2_const", last_c, 32'hFFFF_FFFF);
        do_op("div_ovf", OP_DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_const", last_c, 32'h8000_0000);
        do_op("rem_ovf", OP_DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("rem_ovf_const", last_c, 32'h0000_0000);
        do_op("div_z", OP_DIV_DIV, 32'h1234_5678, 32'd0);
        chk("div_z_const", last_c, 32'hFFFF_FFFF);
        do_op("remu_z", OP_DIV_REMU, 32'h1234_5678, 32'd0);
        chk("remu_z_const", last_c, 32'h1234_5678);
        do_op("divu_z", OP_DIV_DIVU, 32'h8000_0001, 32'd0);
        do_op("rem_z", OP_DIV_REM, 32'hF000_0003, 32'd0);

        // Start while busy is ignored
        start_op(OP_DIV_DIVU, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge i_clk);
            #1;
        end
        i_start = 1'b1;
        i_op    = OP_DIV_DIVU;
        i_a     = 32'd9;
        i_b     = 32'd3;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        wait_done(11, c, cyc, bn);
        chk("busy_start_res", c, 32'h0000_000E);
        chk("busy_start_lat", 32'(cyc), 32'd34);

        // Back-to-back restart in the o_done cycle
        start_op(OP_DIV_DIVU, 32'd9, 32'd3);
        wait_done(1, c, cyc, bn);
        chk("b2b_res", c, 32'h0000_0003);
        chk("b2b_lat", 32'(cyc), 32'd34);

        // Reset mid-operation
        start_op(OP_DIV_DIVU, 32'd100, 32'd7);
        repeat (14) begin
            @(posedge i_clk);
            #1;
        end
        i_rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_c", o_c, 32'd0);
        chk("abort_done", {31'd0, o_done}, 32'd0);
        seen_done = 1'b0;
        repeat (3) begin
            @(posedge i_clk);
            #1;
            if (o_done) seen_done = 1'b1;
        end
        i_rst  = 1'b0;
        last_c = 32'd0;
        repeat (40) begin
            @(posedge i_clk);
            #1;
            if (o_done) seen_done = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen_done}, 32'd0);
        do_op("after_rst", OP_DIV_DIVU, 32'd100, 32'd7);

        // Randomized operations with biased operand classes
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            do_op("rand", rop, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
